// File: rtl/debounce_edge_fsm.sv
// debounce_edge_fsm
//
// Cleans up a raw mechanical switch or button input. There are three stages:
//   1. A two-flop synchronizer brings the asynchronous input into the clk
//      domain.
//   2. A four-state FSM with a down-counter accepts a new level only after
//      it has been stable for a full window of 2**N clock cycles.
//   3. Registered one-cycle ticks mark each accepted rising and falling edge.
//
// Parameters
//   N          counter width; the stable window is 2**N clk cycles (N >= 1)
//
// Ports
//   clk        in   system clock, every flop runs on its rising edge
//   reset      in   synchronous, active-high reset
//   sw         in   raw asynchronous switch input (may bounce)
//   db_level   out  debounced level, registered
//   db_tick    out  one-cycle pulse on a debounced rising edge, registered
//   fall_tick  out  one-cycle pulse on a debounced falling edge, registered

module debounce_edge_fsm #(
   parameter int N = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic sw,
   output logic db_level,
   output logic db_tick,
   output logic fall_tick
);

   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } state_t;

   localparam logic [N-1:0] Q_MAX = '1;
   localparam logic [N-1:0] Q_ONE = N'(1);

   state_t         state;
   state_t         state_next;
   logic [N-1:0]   q;
   logic [N-1:0]   q_next;
   logic           s1;
   logic           s_sync;
   logic           level_next;
   logic           rise_next;
   logic           fall_next;

   // Two-flop synchronizer. Only s_sync is ever seen by the FSM, so a
   // metastable first stage never reaches the decision logic.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1     <= 1'b0;
         s_sync <= 1'b0;
      end else begin
         s1     <= sw;
         s_sync <= s1;
      end
   end

   // State, counter and output registers. The outputs are loaded from the
   // next-state decode, so db_level and the ticks change on the same edge
   // as the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ZERO;
         q         <= '0;
         db_level  <= 1'b0;
         db_tick   <= 1'b0;
         fall_tick <= 1'b0;
      end else begin
         state     <= state_next;
         q         <= q_next;
         db_level  <= level_next;
         db_tick   <= rise_next;
         fall_tick <= fall_next;
      end
   end

   // Next-state and counter logic. A WAIT state loads the counter with the
   // full window on entry and counts down while the new level holds. Any
   // opposite sample drops back to the stable state, so the next attempt
   // starts a fresh window. The counter leaves its WAIT state at zero, so
   // it never wraps.
   always_comb begin
      state_next = state;
      q_next     = q;
      rise_next  = 1'b0;
      fall_next  = 1'b0;

      unique case (state)
         ZERO: begin
            if (s_sync) begin
               state_next = WAIT1;
               q_next     = Q_MAX;
            end
         end
         WAIT1: begin
            if (!s_sync) begin
               state_next = ZERO;
            end else if (q != '0) begin
               q_next = q - Q_ONE;
            end else begin
               state_next = ONE;
               rise_next  = 1'b1;
            end
         end
         ONE: begin
            if (!s_sync) begin
               state_next = WAIT0;
               q_next     = Q_MAX;
            end
         end
         WAIT0: begin
            if (s_sync) begin
               state_next = ONE;
            end else if (q != '0) begin
               q_next = q - Q_ONE;
            end else begin
               state_next = ZERO;
               fall_next  = 1'b1;
            end
         end
         default: begin
            state_next = ZERO;
         end
      endcase

      level_next = (state_next == ONE) || (state_next == WAIT0);
   end

endmodule
